data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Data-memory stage driven by the multicycle controller's MEM-state strobes (DM_CS/DM_R/DM_W).
//  Holds a word-addressed data RAM behind a wait-state sequencer and captures read data in a
//  registered MDR. Raises a one-cycle DM_ready pulse so MEM is held until the access completes.
//  Flags misaligned and out-of-range accesses instead of hanging the CPU.
// PARAMETERS
//  DEPTH_LOG2   10  RAM depth = 2**DEPTH_LOG2 32-bit words
//  WAIT_STATES  2   extra cycles between request accept and the RAM access (0..15)
// PORTS
//  clk       in   1   system clock, all state updates on rising edge
//  reset     in   1   synchronous, active-high reset
//  DM_CS     in   1   access request (chip select)
//  DM_R      in   1   read strobe, sampled with DM_CS
//  DM_W      in   1   write strobe, sampled with DM_CS
//  addr      in   32  byte address (ALUOut)
//  wdata     in   32  store data (rt register)
//  rdata     out  32  MDR: registered read data
//  DM_ready  out  1   one-cycle pulse: access finished (or rejected)
//  DM_err    out  1   valid with DM_ready: request rejected, no RAM access
// BEHAVIOUR
//  Reset
//  - state=IDLE, cnt=0, rdata=0, DM_ready=0, DM_err=0.
//  - A pending write is discarded. RAM contents are not reset.
//  States
//  - IDLE: if DM_CS=1, capture addr/wdata/op in request regs at the edge.
//    - Valid request -> WAIT, cnt=WAIT_STATES.
//    - Invalid request -> DONE with DM_ready=1, DM_err=1.
//  - Invalid = (DM_R & DM_W), or (~DM_R & ~DM_W), or addr[1:0]!=0,
//    or addr[31:DEPTH_LOG2+2]!=0.
//  - WAIT, cnt!=0: cnt<=cnt-1.
//  - WAIT, cnt==0: perform the access at this edge -> DONE, DM_ready=1, DM_err=0.
//    - write: ram[addr[DEPTH_LOG2+1:2]]<=wdata.
//    - read: rdata<=ram[index].
//  - DONE: DM_ready and DM_err are high only in the first DONE cycle, then low.
//    Stay in DONE while DM_CS=1; go to IDLE when DM_CS=0.
//  Timing
//  - If DM_CS first seen high in IDLE in cycle N, DM_ready is high in cycle N+WAIT_STATES+2.
//    With WAIT_STATES=0 this is N+2.
//  - Rejected requests: DM_ready is high in cycle N+1.
//  - rdata updates only on a successful read. It holds its value through writes, errors and
//    idle, and is valid in the DM_ready cycle and afterwards.
//  Boundary rules
//  - DM_CS/DM_R/DM_W/addr/wdata changing or dropping during WAIT is ignored. The captured
//    request completes; there is no abort.
//  - A new request is accepted only from IDLE, so there is no re-trigger while the CPU still
//    holds DM_CS after ready.
//  - Reset in any state wins over the access in the same cycle: no RAM write, no ready.
//  - Read-after-write to the same word in back-to-back requests returns the new data.
//  - cnt is 4 bits wide; WAIT_STATES>15 is illegal.
// TESTING
//  - Write then read, WAIT_STATES=2: sw addr=0x10 data=0xDEADBEEF, then lw 0x10
//    -> DM_ready at N+4 both times, rdata=0xDEADBEEF, DM_err=0.
//  - Misaligned: DM_CS=1, DM_R=1, addr=0x12 -> DM_ready=DM_err=1 at N+1, rdata unchanged,
//    RAM unchanged (read back 0x10).
//  - Out of range (DEPTH_LOG2=10): sw addr=0x1000 -> DM_err=1.
//  - Conflicting strobes: DM_R=DM_W=1 -> DM_err=1.
//  - Hold: DM_CS held high 5 cycles after ready -> exactly one DM_ready pulse, no second access.
//  - Reset mid-op: assert reset while in WAIT with cnt=1 on sw 0x20=0x1234 -> outputs 0, no
//    ready, later lw 0x20 returns the old value.
//  - WAIT_STATES=0 and DM_CS dropped in WAIT: lw -> ready at N+2, access still completes.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// ----------------------------------------------------------------------------
// data_mem_ctrl
// Data-memory stage for the multicycle CPU. Accepts a read or write request
// from the MEM-state strobes, inserts WAIT_STATES wait cycles, then accesses a
// word-addressed RAM. Read data is captured in a registered MDR (rdata).
// A one-cycle DM_ready pulse ends every request. DM_err accompanies DM_ready
// when the request was rejected (misaligned, out of range, or bad strobes).
//
// Ports
//   clk       in   1   system clock (rising edge)
//   reset     in   1   synchronous active-high reset
//   DM_CS     in   1   access request (chip select)
//   DM_R      in   1   read strobe, sampled with DM_CS
//   DM_W      in   1   write strobe, sampled with DM_CS
//   addr      in  32   byte address
//   wdata     in  32   store data
//   rdata     out 32   registered read data (MDR)
//   DM_ready  out  1   one-cycle completion pulse
//   DM_err    out  1   request rejected, qualified by DM_ready
// ----------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        DM_CS,
    input  logic        DM_R,
    input  logic        DM_W,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        DM_ready,
    output logic        DM_err
);

    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned IDX_LSB = 2;
    localparam int unsigned IDX_MSB = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic [31:0]             r_wdata;
    logic                    r_wr;
    logic [31:0]             r_rdata;
    logic                    r_ready;
    logic                    r_err;

    logic [31:0]             r_mem [DEPTH];

    logic                    w_bad_strobe;
    logic                    w_misaligned;
    logic                    w_out_of_range;
    logic                    w_req_bad;
    logic                    w_access;
    logic                    w_mem_we;

    // Request validation: exactly one strobe, word aligned, inside the RAM.
    always_comb begin
        w_bad_strobe   = (DM_R == DM_W);
        w_misaligned   = (addr[1:0] != 2'b00);
        w_out_of_range = ((addr >> (DEPTH_LOG2 + 2)) != 32'd0);
        w_req_bad      = w_bad_strobe | w_misaligned | w_out_of_range;
    end

    // The access edge is the last WAIT cycle; reset in the same cycle cancels it.
    always_comb begin
        w_access = (r_state == S_WAIT) && (r_cnt == CNT_W'(0)) && !reset;
        w_mem_we = w_access && r_wr;
    end

    // RAM array: write port only, contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    // Sequencer: capture in IDLE, count down in WAIT, pulse ready on entry to DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_wr    <= 1'b0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (DM_CS) begin
                        r_idx   <= addr[IDX_MSB:IDX_LSB];
                        r_wdata <= wdata;
                        r_wr    <= DM_W;
                        if (w_req_bad) begin
                            r_state <= S_DONE;
                            r_ready <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= CNT_W'(WAIT_STATES);
                        end
                    end
                end
                S_WAIT: begin
                    // Inputs are ignored here; the captured request always completes.
                    if (r_cnt != CNT_W'(0)) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        if (!r_wr) begin
                            r_rdata <= r_mem[r_idx];
                        end
                        r_state <= S_DONE;
                        r_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Hold here while the CPU keeps DM_CS high to avoid re-triggering.
                    if (!DM_CS) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rdata    = r_rdata;
    assign DM_ready = r_ready;
    assign DM_err   = r_err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_data_mem_ctrl
// Self-checking bench for data_mem_ctrl. Instance 0 uses WAIT_STATES=2,
// instance 1 uses WAIT_STATES=0. Expected completions are queued when a
// request is driven and compared when the DUT raises DM_ready.
// ----------------------------------------------------------------------------
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [2];
    logic        cs   [2];
    logic        rd   [2];
    logic        wr   [2];
    logic [31:0] ad   [2];
    logic [31:0] wd   [2];
    logic [31:0] rdat [2];
    logic        rdy  [2];
    logic        err  [2];

    data_mem_ctrl #(.DEPTH_LOG2(10), .WAIT_STATES(2)) u_dut0 (
        .clk(clk), .reset(rst[0]), .DM_CS(cs[0]), .DM_R(rd[0]), .DM_W(wr[0]),
        .addr(ad[0]), .wdata(wd[0]), .rdata(rdat[0]), .DM_ready(rdy[0]), .DM_err(err[0])
    );

    data_mem_ctrl #(.DEPTH_LOG2(10), .WAIT_STATES(0)) u_dut1 (
        .clk(clk), .reset(rst[1]), .DM_CS(cs[1]), .DM_R(rd[1]), .DM_W(wr[1]),
        .addr(ad[1]), .wdata(wd[1]), .rdata(rdat[1]), .DM_ready(rdy[1]), .DM_err(err[1])
    );

    typedef struct {
        int          sel;
        int          lat;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl[int];
    logic [31:0] last_rd [2];
    int          ws [2];
    int          exp_pulses [2];
    int          pulses [2];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Count every ready pulse so spurious or repeated completions are caught.
    always @(negedge clk) begin
        if (rdy[0] === 1'b1) pulses[0]++;
        if (rdy[1] === 1'b1) pulses[1]++;
    end

    // Drive one request, queue its expectation, wait for ready and compare.
    // drop>0 releases the strobes (and scrambles addr) after that many cycles.
    task automatic issue(input int s, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         input int hold, input int drop, input string tag);
        exp_t e;
        exp_t p;
        int   lat;
        logic got;
        logic bad;
        int   key;
        bad   = (r == w) || (a[1:0] != 2'b00) || ((a >> 12) != 32'd0);
        key   = s * 65536 + int'(a >> 2);
        e.sel = s;
        e.err = bad;
        e.lat = bad ? 1 : ws[s] + 2;
        if (!bad && w) mdl[key] = d;
        if (!bad && r) last_rd[s] = mdl.exists(key) ? mdl[key] : 32'hBAD0_BAD0;
        e.rdata = last_rd[s];
        sb.push_back(e);
        exp_pulses[s]++;

        cs[s] = 1'b1; rd[s] = r; wr[s] = w; ad[s] = a; wd[s] = d;
        lat = 0;
        got = 1'b0;
        while (lat < 40 && !got) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (drop > 0 && lat == drop && rdy[s] !== 1'b1) begin
                cs[s] = 1'b0; rd[s] = 1'b0; wr[s] = ~w; ad[s] = 32'h0000_0FF0; wd[s] = 32'h1;
            end
            if (rdy[s] === 1'b1) got = 1'b1;
        end
        p = sb.pop_front();
        check({tag, "/ready"}, 32'(got), 32'd1);
        check({tag, "/latency"}, 32'(lat), 32'(p.lat));
        check({tag, "/err"}, 32'(err[s]), 32'(p.err));
        check({tag, "/rdata"}, rdat[s], p.rdata);
        repeat (hold) @(negedge clk);
        cs[s] = 1'b0; rd[s] = 1'b0; wr[s] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        ws[0] = 2; ws[1] = 0;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; cs[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0;
            ad[i] = '0; wd[i] = '0; last_rd[i] = '0;
            exp_pulses[i] = 0; pulses[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset/rdata", rdat[i], 32'd0);
            check("reset/ready", 32'(rdy[i]), 32'd0);
            check("reset/err", 32'(err[i]), 32'd0);
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);

        // Write then read back, WAIT_STATES=2.
        issue(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, 0, "sw10");
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 0, 0, "lw10");
        // Rejected requests leave rdata and RAM untouched.
        issue(0, 1'b1, 1'b0, 32'h12, 32'h0, 0, 0, "misalign");
        issue(0, 1'b0, 1'b1, 32'h1000, 32'h1111_1111, 0, 0, "range");
        issue(0, 1'b1, 1'b1, 32'h10, 32'h2222_2222, 0, 0, "both");
        issue(0, 1'b0, 1'b0, 32'h10, 32'h3333_3333, 0, 0, "none");
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 0, 0, "lw10b");
        // Highest word in range, then back-to-back read-after-write.
        issue(0, 1'b0, 1'b1, 32'hFFC, 32'h0BAD_F00D, 0, 0, "swtop");
        issue(0, 1'b1, 1'b0, 32'hFFC, 32'h0, 0, 0, "lwtop");
        // DM_CS held after ready: a single completion only.
        issue(0, 1'b0, 1'b1, 32'h14, 32'h0000_0055, 5, 0, "hold");
        issue(0, 1'b1, 1'b0, 32'h14, 32'h0, 0, 0, "raw14");

        // Reset while in WAIT with cnt=1 kills the pending write.
        issue(0, 1'b0, 1'b1, 32'h20, 32'h0000_AAAA, 0, 0, "sw20old");
        cs[0] = 1'b1; rd[0] = 1'b0; wr[0] = 1'b1; ad[0] = 32'h20; wd[0] = 32'h0000_1234;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst/rdata", rdat[0], 32'd0);
        check("midrst/ready", 32'(rdy[0]), 32'd0);
        check("midrst/err", 32'(err[0]), 32'd0);
        rst[0] = 1'b0; cs[0] = 1'b0; wr[0] = 1'b0;
        last_rd[0] = 32'd0;
        repeat (6) @(negedge clk);
        issue(0, 1'b1, 1'b0, 32'h20, 32'h0, 0, 0, "lw20");

        // WAIT_STATES=0, strobes dropped during WAIT.
        issue(1, 1'b0, 1'b1, 32'h8, 32'hCAFE_F00D, 0, 0, "ws0sw");
        issue(1, 1'b1, 1'b0, 32'h8, 32'h0, 0, 1, "ws0drop");
        issue(1, 1'b0, 1'b1, 32'h7, 32'h5, 0, 0, "ws0mis");

        // Random aligned write/read pairs on both instances.
        for (int i = 0; i < 8; i++) begin
            int          s;
            logic [31:0] a;
            logic [31:0] d;
            s = i % 2;
            a = 32'($urandom_range(0, 1023)) << 2;
            d = $urandom;
            issue(s, 1'b0, 1'b1, a, d, 0, 0, "rndw");
            issue(s, 1'b1, 1'b0, a, 32'h0, 0, 0, "rndr");
        end

        repeat (5) @(negedge clk);
        check("pulses0", 32'(pulses[0]), 32'(exp_pulses[0]));
        check("pulses1", 32'(pulses[1]), 32'(exp_pulses[1]));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
